// File: rtl/mips32_alu_pkg.sv
// Shared definitions for the MIPS32 ALU-op encoder: ALU_op codes, opcode/funct
// values and the decoded control bundle.
package mips32_alu_pkg;

    localparam logic [3:0] ALU_OP_ADDU = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OP_SUBU = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0011;
    localparam logic [3:0] ALU_OP_AND  = 4'b0100;
    localparam logic [3:0] ALU_OP_OR   = 4'b0101;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0110;
    localparam logic [3:0] ALU_OP_NOR  = 4'b0111;
    localparam logic [3:0] ALU_OP_LUI  = 4'b1000;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1001;
    localparam logic [3:0] ALU_OP_SLTU = 4'b1010;
    localparam logic [3:0] ALU_OP_SLT  = 4'b1011;
    localparam logic [3:0] ALU_OP_SLL  = 4'b1110;
    localparam logic [3:0] ALU_OP_SRL  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       imm_sel;
        logic       imm_zext;
        logic       ovf_en;
        logic       illegal;
    } dec_t;

    localparam dec_t DEC_ZERO    = '{alu_op: ALU_OP_ADDU, imm_sel: 1'b0, imm_zext: 1'b0,
                                     ovf_en: 1'b0, illegal: 1'b0};
    localparam dec_t DEC_ILLEGAL = '{alu_op: ALU_OP_ADDU, imm_sel: 1'b0, imm_zext: 1'b0,
                                     ovf_en: 1'b0, illegal: 1'b1};

    function automatic dec_t dec_ok(input logic [3:0] op, input logic sel,
                                    input logic zext, input logic ovf);
        dec_t d;
        d.alu_op   = op;
        d.imm_sel  = sel;
        d.imm_zext = zext;
        d.ovf_en   = ovf;
        d.illegal  = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/mips32_instr_dec.sv
// Pure combinational mapping from a MIPS32 instruction word to the ALU control
// bundle; unrecognised encodings yield the illegal bundle (ALU_op = ADDU).
module mips32_instr_dec
    import mips32_alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[31:26];
    assign w_funct         = i_instr[5:0];
    // Register and immediate fields do not influence the ALU operation.
    assign w_unused_fields = ^i_instr[25:6];

    always_comb begin
        // NOTE: default assigned first so every path drives o_dec and no latch is inferred.
        o_dec = DEC_ILLEGAL;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  o_dec = dec_ok(ALU_OP_ADD,  1'b0, 1'b0, 1'b1);
                    FN_ADDU: o_dec = dec_ok(ALU_OP_ADDU, 1'b0, 1'b0, 1'b0);
                    FN_SUB:  o_dec = dec_ok(ALU_OP_SUB,  1'b0, 1'b0, 1'b1);
                    FN_SUBU: o_dec = dec_ok(ALU_OP_SUBU, 1'b0, 1'b0, 1'b0);
                    FN_AND:  o_dec = dec_ok(ALU_OP_AND,  1'b0, 1'b0, 1'b0);
                    FN_OR:   o_dec = dec_ok(ALU_OP_OR,   1'b0, 1'b0, 1'b0);
                    FN_XOR:  o_dec = dec_ok(ALU_OP_XOR,  1'b0, 1'b0, 1'b0);
                    FN_NOR:  o_dec = dec_ok(ALU_OP_NOR,  1'b0, 1'b0, 1'b0);
                    FN_SLT:  o_dec = dec_ok(ALU_OP_SLT,  1'b0, 1'b0, 1'b0);
                    FN_SLTU: o_dec = dec_ok(ALU_OP_SLTU, 1'b0, 1'b0, 1'b0);
                    FN_SLL:  o_dec = dec_ok(ALU_OP_SLL,  1'b0, 1'b0, 1'b0);
                    FN_SRL:  o_dec = dec_ok(ALU_OP_SRL,  1'b0, 1'b0, 1'b0);
                    FN_SRA:  o_dec = dec_ok(ALU_OP_SRA,  1'b0, 1'b0, 1'b0);
                    default: o_dec = DEC_ILLEGAL;
                endcase
            end
            OP_ADDI:  o_dec = dec_ok(ALU_OP_ADD,  1'b1, 1'b0, 1'b1);
            OP_ADDIU: o_dec = dec_ok(ALU_OP_ADDU, 1'b1, 1'b0, 1'b0);
            OP_SLTI:  o_dec = dec_ok(ALU_OP_SLT,  1'b1, 1'b0, 1'b0);
            OP_SLTIU: o_dec = dec_ok(ALU_OP_SLTU, 1'b1, 1'b0, 1'b0);
            OP_ANDI:  o_dec = dec_ok(ALU_OP_AND,  1'b1, 1'b1, 1'b0);
            OP_ORI:   o_dec = dec_ok(ALU_OP_OR,   1'b1, 1'b1, 1'b0);
            OP_XORI:  o_dec = dec_ok(ALU_OP_XOR,  1'b1, 1'b1, 1'b0);
            OP_LUI:   o_dec = dec_ok(ALU_OP_LUI,  1'b1, 1'b1, 1'b0);
            OP_LW,
            OP_SW:    o_dec = dec_ok(ALU_OP_ADDU, 1'b1, 1'b0, 1'b0);
            // Branches compare registers, so the second operand stays rt.
            OP_BEQ,
            OP_BNE:   o_dec = dec_ok(ALU_OP_SUBU, 1'b0, 1'b0, 1'b0);
            default:  o_dec = DEC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips32_alu_op_enc.sv
// Decode-stage ALU-op encoder: registered valid/ready with a main + skid output
// buffer so in_ready never depends combinationally on out_ready.
module mips32_alu_op_enc
    import mips32_alu_pkg::*;
#(
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_op,
    output logic             imm_sel,
    output logic             imm_zext,
    output logic             ovf_en,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t             w_dec;
    logic             w_accept;
    logic             w_main_free;

    logic             r_main_valid;
    dec_t             r_main;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    dec_t             r_skid;
    logic [TAG_W-1:0] r_skid_tag;
    logic [CNT_W-1:0] r_illegal_cnt;

    mips32_instr_dec u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && !r_skid_valid;
    assign w_main_free = !r_main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload registers are reset as well as the valid bits, so every
        // data output reads zero straight out of reset.
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main       <= DEC_ZERO;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= DEC_ZERO;
            r_skid_tag   <= '0;
        end else if (w_main_free) begin
            // Skid holds the older entry, so it always refills main first.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main       <= r_skid;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main     <= w_dec;
                    r_main_tag <= in_tag;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_dec;
            r_skid_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_dec.illegal && !(&r_illegal_cnt)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign out_valid   = r_main_valid;
    assign ALU_op      = r_main.alu_op;
    assign imm_sel     = r_main.imm_sel;
    assign imm_zext    = r_main.imm_zext;
    assign ovf_en      = r_main.ovf_en;
    assign illegal     = r_main.illegal;
    assign out_tag     = r_main_tag;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_mips32_alu_op_enc.sv
// Scoreboard bench for mips32_alu_op_enc: the driver pushes hand-computed
// expectations on acceptance, a monitor pops and compares on each output transfer.
module tb_mips32_alu_op_enc;

    typedef struct {
        logic [3:0] op;
        logic       sel;
        logic       zext;
        logic       ovf;
        logic       ill;
        logic [7:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALU_op;
    logic        imm_sel;
    logic        imm_zext;
    logic        ovf_en;
    logic        illegal;
    logic [7:0]  out_tag;
    logic [15:0] illegal_cnt;

    logic        unused_in_ready, unused_out_valid, unused_imm_sel, unused_imm_zext;
    logic        unused_ovf_en, unused_illegal;
    logic [3:0]  unused_alu_op;
    logic [7:0]  unused_out_tag;
    logic [1:0]  cnt2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    always #5 clk = ~clk;

    mips32_alu_op_enc #(.TAG_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_op(ALU_op), .imm_sel(imm_sel), .imm_zext(imm_zext), .ovf_en(ovf_en),
        .illegal(illegal), .out_tag(out_tag), .illegal_cnt(illegal_cnt)
    );

    // Narrow-counter instance sees the same stream; only its counter is checked.
    mips32_alu_op_enc #(.TAG_W(8), .CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(unused_out_valid),
        .out_ready(out_ready), .ALU_op(unused_alu_op), .imm_sel(unused_imm_sel),
        .imm_zext(unused_imm_zext), .ovf_en(unused_ovf_en), .illegal(unused_illegal),
        .out_tag(unused_out_tag), .illegal_cnt(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic sel, input logic zext,
                                input logic ovf, input logic ill);
        exp_t e;
        e.op = op; e.sel = sel; e.zext = zext; e.ovf = ovf; e.ill = ill; e.tag = 8'h00;
        return e;
    endfunction

    function automatic exp_t exp_rtype(input logic [5:0] f);
        case (f)
            6'h20:   return mk(4'b0001, 0, 0, 1, 0);
            6'h21:   return mk(4'b0000, 0, 0, 0, 0);
            6'h22:   return mk(4'b0011, 0, 0, 1, 0);
            6'h23:   return mk(4'b0010, 0, 0, 0, 0);
            6'h24:   return mk(4'b0100, 0, 0, 0, 0);
            6'h25:   return mk(4'b0101, 0, 0, 0, 0);
            6'h26:   return mk(4'b0110, 0, 0, 0, 0);
            6'h27:   return mk(4'b0111, 0, 0, 0, 0);
            6'h2A:   return mk(4'b1011, 0, 0, 0, 0);
            6'h2B:   return mk(4'b1010, 0, 0, 0, 0);
            6'h00:   return mk(4'b1110, 0, 0, 0, 0);
            6'h02:   return mk(4'b1111, 0, 0, 0, 0);
            6'h03:   return mk(4'b1001, 0, 0, 0, 0);
            default: return mk(4'b0000, 0, 0, 0, 1);
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] instr, input logic [7:0] tag, input exp_t e);
        int waited = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: tag 0x%0h not accepted within 100 cycles", tag);
        end else begin
            e.tag = tag;
            sb.push_back(e);
            if (e.ill) exp_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: judges the transfer that will occur at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: tag 0x%0h with empty scoreboard", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("out_tag",  {24'h0, out_tag}, {24'h0, e.tag});
                    check("ALU_op",   {28'h0, ALU_op},  {28'h0, e.op});
                    check("imm_sel",  {31'h0, imm_sel},  {31'h0, e.sel});
                    check("imm_zext", {31'h0, imm_zext}, {31'h0, e.zext});
                    check("ovf_en",   {31'h0, ovf_en},   {31'h0, e.ovf});
                    check("illegal",  {31'h0, illegal},  {31'h0, e.ill});
                    check("op_not_reserved", {31'h0, (ALU_op == 4'b1100 || ALU_op == 4'b1101)}, 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 0);
        check({tag, "_in_ready"},  {31'h0, in_ready},  1);
        check({tag, "_ALU_op"},    {28'h0, ALU_op},    0);
        check({tag, "_out_tag"},   {24'h0, out_tag},   0);
        check({tag, "_cnt"},       {16'h0, illegal_cnt}, 0);
        check({tag, "_cnt2"},      {30'h0, cnt2},      0);
    endtask

    initial begin
        int waited;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_tag    = 8'h0;
        out_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add, then andi / lw / beq back to back with the output always ready.
        send(32'h00221820, 8'h10, mk(4'b0001, 0, 0, 1, 0));
        send(32'h3022FFFF, 8'h11, mk(4'b0100, 1, 1, 0, 0));
        send(32'h8C220004, 8'h12, mk(4'b0000, 1, 0, 0, 0));
        send(32'h10220003, 8'h13, mk(4'b0010, 0, 0, 0, 0));
        repeat (2) @(negedge clk);

        // Stall: two entries fill main + skid, third waits until the output drains.
        out_ready = 1'b0;
        fork
            begin
                send(32'h20220005, 8'h01, mk(4'b0001, 1, 0, 1, 0));
                send(32'h34220001, 8'h02, mk(4'b0101, 1, 1, 0, 0));
                check("stall_in_ready", {31'h0, in_ready}, 0);
                send(32'h0022182A, 8'h03, mk(4'b1011, 0, 0, 0, 0));
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);

        // Illegal encodings and counter saturation on the 2-bit instance.
        send(32'hFC000000, 8'h20, mk(4'b0000, 0, 0, 0, 1));
        check("cnt_first_illegal", {16'h0, illegal_cnt}, 1);
        send(32'hFC000000, 8'h21, mk(4'b0000, 0, 0, 0, 1));
        send(32'h00000001, 8'h22, mk(4'b0000, 0, 0, 0, 1));
        send(32'hFC000000, 8'h23, mk(4'b0000, 0, 0, 0, 1));
        send(32'h00000001, 8'h24, mk(4'b0000, 0, 0, 0, 1));
        check("cnt_after_five", {16'h0, illegal_cnt}, 5);
        check("cnt2_saturated", {30'h0, cnt2}, 3);

        // Sweep every R-type funct.
        for (int f = 0; f < 64; f++) begin
            logic [5:0] fn;
            fn = f[5:0];
            send({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn}, f[7:0] + 8'h40, exp_rtype(fn));
        end
        @(negedge clk);
        check("cnt_after_sweep", {16'h0, illegal_cnt}, 32'(exp_cnt));
        check("cnt2_still_sat",  {30'h0, cnt2}, 3);

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_before_reset", sb.size(), 0);

        // Fill main + skid, then reset asynchronously between clock edges.
        out_ready = 1'b0;
        send(32'h00221820, 8'h30, mk(4'b0001, 0, 0, 1, 0));
        send(32'hFC000000, 8'h31, mk(4'b0000, 0, 0, 0, 1));
        check("full_in_ready",  {31'h0, in_ready},  0);
        check("full_out_valid", {31'h0, out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        send(32'h00221820, 8'h50, mk(4'b0001, 0, 0, 1, 0));
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("final_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips32_alu_op_enc.md
Name: mips32_alu_op_enc

Overview:
- Decode-stage encoder that turns a 32-bit MIPS instruction word into the 4-bit ALU_op consumed by mips32_alu_ctrl, plus operand-select side signals.
- Sits between instruction fetch and the ALU control decoder.
- Registered valid/ready on both sides, with a 2-entry (main + skid) output buffer so in_ready never depends combinationally on out_ready.

Parameters:
- TAG_W, 8: width of the opaque tag (e.g. PC low bits) carried alongside each instruction.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction word present.
- in_ready  out  1  encoder can accept this cycle.
- in_instr  in  32  MIPS instruction word.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  encoded entry present.
- out_ready  in  1  downstream accepts.
- ALU_op  out  4  encoded ALU operation.
- imm_sel  out  1  second operand is the immediate.
- imm_zext  out  1  immediate is zero-extended (0 = sign-extended).
- ovf_en  out  1  overflow trap enabled.
- illegal  out  1  unrecognised instruction; ALU_op forced to ADDU.
- out_tag  out  TAG_W  tag of the entry on the output.
- illegal_cnt  out  CNT_W  saturating count of illegal entries accepted.

Behaviour:
- Reset (async assert, sync release): both buffer entries invalid; out_valid=0, in_ready=1. All data outputs 0, so ALU_op=0000. illegal_cnt=0.
- ALU_op encoding (package constants):
  - 0000 ADDU, 0001 ADD, 0010 SUBU, 0011 SUB
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
  - 1000 LUI, 1001 SRA, 1010 SLTU, 1011 SLT
  - 1110 SLL, 1111 SRL
  - 1100 and 1101 are never emitted.
- R-type (op 000000), by funct:
  - 100000→ADD, 100001→ADDU, 100010→SUB, 100011→SUBU
  - 100100→AND, 100101→OR, 100110→XOR, 100111→NOR
  - 101010→SLT, 101011→SLTU
  - 000000→SLL, 000010→SRL, 000011→SRA
  - For all R-type: imm_sel=0.
- I-type (imm_sel=1):
  - addi 001000→ADD; addiu 001001→ADDU; slti 001010→SLT; sltiu 001011→SLTU (all sign-extended).
  - andi 001100→AND, ori 001101→OR, xori 001110→XOR, lui 001111→LUI (all imm_zext=1).
  - lw 100011 and sw 101011→ADDU, sign-extended.
  - beq 000100 and bne 000101→SUBU with imm_sel=0.
- ovf_en=1 only for ADD and SUB (add, sub, addi).
- Any other opcode/funct: illegal=1, ALU_op=0000, imm_sel=0, imm_zext=0, ovf_en=0.
- Latency: 1 cycle. An instruction accepted in cycle N (in_valid & in_ready) appears with out_valid=1 in cycle N+1, provided the main entry is empty or draining.
- Buffer:
  - in_ready is registered and equals !skid_valid.
  - If out_ready=0 while main is valid and a new input is accepted, the new entry goes to skid.
  - When main drains, skid moves to main in the same edge and skid clears.
  - Order is always preserved; no entry is dropped or duplicated.
- Simultaneous accept and drain with skid empty: main is replaced by the new entry; out_valid stays 1.
- Output stability: while out_valid=1 and out_ready=0, all out_* and ALU_op hold.
- illegal_cnt increments on acceptance of an illegal instruction, saturates at all-ones and never wraps.
- Reset mid-operation flushes both entries immediately (async). Entries in flight are lost; the counter clears.

Decomposition:
- Package mips32_alu_pkg:
  - ALU_op localparams (ALU_OP_ADDU … ALU_OP_SRL).
  - Opcode and funct localparams.
  - A struct/packed bundle {alu_op, imm_sel, imm_zext, ovf_en, illegal}.
- One sub-module: mips32_instr_dec, a pure combinational instruction→bundle mapper.
- The top level holds the main/skid buffer, handshake and counter.

Test Plan:
- Reset then `add $3,$1,$2` (0x00221820), out_ready=1 → next cycle out_valid=1, ALU_op=0001, imm_sel=0, ovf_en=1, illegal=0.
- Back-to-back stream `andi` 0x3022FFFF, `lw` 0x8C220004, `beq` 0x10220003 with out_ready=1 → ALU_op 0100/0000/0010 on consecutive cycles; imm_zext 1/0/0; imm_sel 1/1/0.
- out_ready=0 for 3 cycles while feeding 3 instructions → first two held (main+skid), in_ready=0 from cycle 2. Third accepted only after out_ready=1; outputs emerge in order with tags 0x01, 0x02, 0x03.
- Illegal opcode 0xFC000000 → illegal=1, ALU_op=0000, illegal_cnt=1. Force CNT_W=2 and send 5 illegals → illegal_cnt saturates at 3.
- Assert rst_n=0 mid-stall with both entries full → out_valid=0, in_ready=1 and ALU_op=0000 without waiting for a clock edge.
- Sweep all 64 R-type functs → ALU_op never equals 1100 or 1101, and every unlisted funct gives illegal=1.
